uart_tx: RTL and testbench

Serial transmit stage that drains bytes from an upstream `sync_fifo` and shifts them out as standard 8N1-style UART frames. It sits directly downstream of the FIFO's read port. It pops one word when the FIFO is non-empty and the transmitter is idle. It serializes each word LSB-first with one start bit and one stop bit, at a fixed bit period given in clock cycles.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_tx.sv | 116 +++++++++++
 tb/tb_uart_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and default parameters.
// Reused by uart_tx and uart_rx.
package uart_pkg;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int UART_DATA_WIDTH           = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and pulses o_tick
// for one cycle on the terminal count, then wraps to 0.
// Ports:
//   clk, n_rst : clock, async active-low reset
//   i_en       : count enable
//   i_clr      : synchronous clear (wins over enable)
//   o_tick     : single-cycle terminal-count pulse
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = i_en && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)     cnt_d = '0;
    else if (i_en) cnt_d = o_tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed from a sync_fifo read port. Pops one word when idle and
// the FIFO is non-empty, then sends start bit, DATA_WIDTH bits LSB-first and
// one stop bit, each CLKS_PER_BIT cycles long.
// Ports:
//   clk, n_rst    : clock, async active-low reset
//   i_fifo_empty  : FIFO empty flag
//   o_fifo_rd_en  : FIFO pop (data valid on i_fifo_data next cycle)
//   i_fifo_data   : FIFO read data, sampled only in LOAD
//   o_tx          : registered serial line, idle high
//   o_busy        : registered, high whenever a word is in flight
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int            BW   = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  uart_tx_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  rd_en;
  logic                  baud_en, baud_clr, tick;

  assign baud_en  = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign baud_clr = (state_q == LOAD);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_en   (baud_en),
    .i_clr  (baud_clr),
    .o_tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rd_en     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!i_fifo_empty) begin
          rd_en   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d   = i_fifo_data;
        bit_cnt_d = '0;
        tx_d      = 1'b0;  // start bit appears on the edge entering START
        state_d   = START;
      end
      START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // next bit is what lands in [0] after this shift
            tx_d = shift_q[1];
          end
        end
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Gate with reset so no pop is requested while held in reset.
  assign o_fifo_rd_en = rd_en && n_rst;
  assign o_tx         = tx_q;
  assign o_busy       = busy_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int DW   = 8;
  localparam int CPB  = 4;
  localparam int CPB2 = 2;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: tasks write mem/push_cnt, the posedge model advances pop_cnt
  logic [DW-1:0] mem_a [0:63];
  logic [DW-1:0] mem_b [0:63];
  int push_cnt_a = 0, pop_cnt_a = 0, push_cnt_b = 0, pop_cnt_b = 0;
  logic empty_a, empty_b, rd_a, rd_b, tx_a, tx_b, busy_a, busy_b;
  logic [DW-1:0] data_a = '0, data_b = '0;
  assign empty_a = (push_cnt_a == pop_cnt_a);
  assign empty_b = (push_cnt_b == pop_cnt_b);

  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .n_rst(n_rst), .i_fifo_empty(empty_a), .o_fifo_rd_en(rd_a),
    .i_fifo_data(data_a), .o_tx(tx_a), .o_busy(busy_a));

  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB2)) dut_b (
    .clk(clk), .n_rst(n_rst), .i_fifo_empty(empty_b), .o_fifo_rd_en(rd_b),
    .i_fifo_data(data_b), .o_tx(tx_b), .o_busy(busy_b));

  int checks = 0, failures = 0;
  int cyc = 0, last_pop_cyc = 0, rd_cnt_a = 0, rd_cnt_b = 0, busy_cnt_a = 0, bad_pop = 0;
  logic exp_q[$];

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    busy_cnt_a <= busy_cnt_a + (busy_a ? 1 : 0);
    if (rd_a) begin
      if (empty_a) bad_pop <= bad_pop + 1;
      data_a       <= mem_a[pop_cnt_a[5:0]];
      pop_cnt_a    <= pop_cnt_a + 1;
      rd_cnt_a     <= rd_cnt_a + 1;
      last_pop_cyc <= cyc;
    end
    if (rd_b) begin
      if (empty_b) bad_pop <= bad_pop + 1;
      data_b    <= mem_b[pop_cnt_b[5:0]];
      pop_cnt_b <= pop_cnt_b + 1;
      rd_cnt_b  <= rd_cnt_b + 1;
    end
  end

  // Load a word into a FIFO model and push its expected line pattern.
  task automatic push_word(input bit sel, input logic [DW-1:0] v, input int cpb);
    if (sel) begin mem_b[push_cnt_b[5:0]] = v; push_cnt_b++; end
    else     begin mem_a[push_cnt_a[5:0]] = v; push_cnt_a++; end
    for (int k = 0; k < cpb; k++) exp_q.push_back(1'b0);
    for (int b = 0; b < DW; b++)
      for (int k = 0; k < cpb; k++) exp_q.push_back(v[b]);
    for (int k = 0; k < cpb; k++) exp_q.push_back(1'b1);
  endtask

  task automatic wait_start(input bit sel, input string name, output bit ok);
    int w;
    w = 0;
    while (((sel ? tx_b : tx_a) !== 1'b0) && w < 60) begin @(negedge clk); w++; end
    ok = (w < 60);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_start: no start bit after %0d cycles, required within 60", name, w);
      exp_q.delete();
    end
  endtask

  task automatic check_bits(input bit sel, input string name);
    int i;
    logic e, o;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = sel ? tx_b : tx_a;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s_bit%0d: tx=%b expected %b", name, i, o, e);
      end
      i++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad, pops0;
    bad = 0;
    n_rst = 1'b0;
    @(negedge clk);
    pops0 = pop_cnt_a;
    push_word(1'b0, 8'h5A, CPB);  // FIFO non-empty while in reset
    exp_q.delete();
    repeat (10) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || rd_a !== 1'b0 ||
          tx_b !== 1'b1 || busy_b !== 1'b0 || rd_b !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_outputs: %0d bad cycles (tx=%b busy=%b rd=%b), expected 0", bad, tx_a, busy_a, rd_a);
    end
    checks++;
    if (pop_cnt_a != pops0) begin
      failures++;
      $display("FAIL reset_no_pop: pops=%0d expected 0", pop_cnt_a - pops0);
    end
    push_cnt_a = pop_cnt_a;  // drain the model before releasing
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int rd0, b0;
    bit ok;
    rd0 = rd_cnt_a; b0 = busy_cnt_a;
    push_word(1'b0, 8'hA5, CPB);
    wait_start(1'b0, "single", ok);
    if (ok) begin
      checks++;
      if (cyc - last_pop_cyc != 2) begin
        failures++;
        $display("FAIL single_latency: pop->start=%0d expected 2", cyc - last_pop_cyc);
      end
      check_bits(1'b0, "single");
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt_a - rd0 != 1) begin
      failures++;
      $display("FAIL single_pops: %0d expected 1", rd_cnt_a - rd0);
    end
    checks++;
    if (busy_cnt_a - b0 != 41) begin
      failures++;
      $display("FAIL single_busy: %0d cycles expected 41", busy_cnt_a - b0);
    end
  endtask

  task automatic test_back_to_back();
    int rd0;
    bit ok;
    logic tmp[$];
    rd0 = rd_cnt_a;
    push_word(1'b0, 8'h00, CPB);
    exp_q.push_back(1'b1);  // IDLE + LOAD between frames
    exp_q.push_back(1'b1);
    push_word(1'b0, 8'hFF, CPB);
    wait_start(1'b0, "b2b", ok);
    if (ok) check_bits(1'b0, "b2b");
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt_a - rd0 != 2) begin
      failures++;
      $display("FAIL b2b_pops: %0d expected 2", rd_cnt_a - rd0);
    end
  endtask

  task automatic test_idle();
    int bad, rd0;
    bad = 0; rd0 = rd_cnt_a;
    repeat (100) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || rd_a !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rd_cnt_a != rd0) begin
      failures++;
      $display("FAIL idle: bad_cycles=%0d pops=%0d expected 0 and 0", bad, rd_cnt_a - rd0);
    end
  endtask

  task automatic test_reset_mid();
    int rd0, bad;
    bit ok;
    push_word(1'b0, 8'h3C, CPB);
    exp_q.delete();
    wait_start(1'b0, "rstmid", ok);
    if (ok) begin
      repeat (CPB + 3 * CPB + 1) @(negedge clk);  // second cycle of data bit 3
      checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_bit3: tx=%b busy=%b expected 1 1", tx_a, busy_a);
      end
      rd0 = rd_cnt_a;
      n_rst = 1'b0;
      #1;
      checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_async: tx=%b busy=%b expected 1 0", tx_a, busy_a);
      end
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      bad = 0;
      repeat (30) begin
        @(negedge clk);
        if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || rd_cnt_a != rd0) begin
        failures++;
        $display("FAIL rstmid_after: bad_cycles=%0d pops=%0d expected 0 and 0", bad, rd_cnt_a - rd0);
      end
    end
  endtask

  task automatic test_cpb2();
    int rd0;
    bit ok;
    rd0 = rd_cnt_b;
    push_word(1'b1, 8'h81, CPB2);
    checks++;
    if (exp_q.size() != 20) begin
      failures++;
      $display("FAIL cpb2_len: %0d expected 20", exp_q.size());
    end
    wait_start(1'b1, "cpb2", ok);
    if (ok) check_bits(1'b1, "cpb2");
    repeat (4) @(negedge clk);
    checks++;
    if (rd_cnt_b - rd0 != 1 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL cpb2_end: pops=%0d busy=%b expected 1 0", rd_cnt_b - rd0, busy_b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_idle();
    test_reset_mid();
    test_cpb2();
    checks++;
    if (bad_pop != 0) begin
      failures++;
      $display("FAIL pop_when_empty: %0d expected 0", bad_pop);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
